// File: rtl/fsm_cc8_in_cond.sv
// Input conditioner for the cc8 control FSM: sync, debounce and edge-detect
// the raw go/jmp/sk0/sk1 inputs into clean clock-aligned controls.
module fsm_cc8_in_cond #(
   parameter int DEB_CNT   = 4,
   parameter int CNT_W     = 3,
   parameter int JMP_PULSE = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic go_raw,
   input  logic jmp_raw,
   input  logic sk0_raw,
   input  logic sk1_raw,
   output logic go,
   output logic jmp,
   output logic sk0,
   output logic sk1
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

   // channel order: 0 go, 1 jmp, 2 sk0, 3 sk1
   logic [3:0]       raw;
   logic [3:0]       s1_q, s2_q;
   logic [3:0]       lvl_q, lvl_d;
   logic [3:0]       rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   assign raw = {sk1_raw, sk0_raw, jmp_raw, go_raw};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         lvl_q  <= '0;
         rise_q <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         s1_q   <= raw;
         s2_q   <= s1_q;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != lvl_q[i]) begin
            if (cnt_q[i] == CNT_MAX) lvl_d[i] = s2_q[i];
            else cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      rise_d = lvl_d & ~lvl_q;
   end

   always_comb begin
      go  = rise_q[0];
      jmp = (JMP_PULSE != 0) ? rise_q[1] : lvl_q[1];
      sk0 = lvl_q[2];
      sk1 = lvl_q[3];
   end

endmodule

// File: tb/tb_fsm_cc8_in_cond.sv
// Bench for fsm_cc8_in_cond: segment table, latency/glitch/reset sequences
// and random stimulus against a sliding-window debounce model.
module tb_fsm_cc8_in_cond;

   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic go_raw = 1'b0, jmp_raw = 1'b0, sk0_raw = 1'b0, sk1_raw = 1'b0;
   logic go, jmp, sk0, sk1;
   logic go_p, jmp_p, sk0_p, sk1_p;

   always #5 clk = ~clk;

   fsm_cc8_in_cond #(.DEB_CNT(DEB), .CNT_W(3), .JMP_PULSE(0)) dut_l (
      .clk(clk), .rst(rst),
      .go_raw(go_raw), .jmp_raw(jmp_raw), .sk0_raw(sk0_raw), .sk1_raw(sk1_raw),
      .go(go), .jmp(jmp), .sk0(sk0), .sk1(sk1)
   );

   fsm_cc8_in_cond #(.DEB_CNT(DEB), .CNT_W(3), .JMP_PULSE(1)) dut_p (
      .clk(clk), .rst(rst),
      .go_raw(go_raw), .jmp_raw(jmp_raw), .sk0_raw(sk0_raw), .sk1_raw(sk1_raw),
      .go(go_p), .jmp(jmp_p), .sk0(sk0_p), .sk1(sk1_p)
   );

   int ncmp = 0;
   int nerr = 0;

   // model: hist[c][0] is the newest raw sample, hist[c][1..DEB] the last
   // DEB synchronised values; the level flips when all DEB disagree with it
   bit hist [4][DEB+1];
   bit mlvl [4];
   bit mrise [4];

   typedef struct {
      bit [3:0] raw;
      int       cyc;
      bit [4:0] fin;
      int       gop;
      int       jpp;
      int       jlv;
   } seg_t;

   seg_t tbl [10];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(bit r, bit [3:0] raw);
      rst = r;
      {sk1_raw, sk0_raw, jmp_raw, go_raw} = raw;
   endtask

   task automatic model_edge();
      bit [3:0] raw;
      raw = {sk1_raw, sk0_raw, jmp_raw, go_raw};
      for (int c = 0; c < 4; c++) begin
         if (rst) begin
            for (int k = 0; k <= DEB; k++) hist[c][k] = 1'b0;
            mlvl[c]  = 1'b0;
            mrise[c] = 1'b0;
         end else begin
            bit flip;
            bit nl;
            flip = 1'b1;
            for (int k = 1; k <= DEB; k++)
               if (hist[c][k] == mlvl[c]) flip = 1'b0;
            nl = flip ? ~mlvl[c] : mlvl[c];
            mrise[c] = nl & ~mlvl[c];
            mlvl[c]  = nl;
            for (int k = DEB; k >= 1; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = raw[c];
         end
      end
   endtask

   task automatic tick();
      logic [7:0] act, exp;
      @(posedge clk);
      model_edge();
      #1;
      act = {sk1_p, sk0_p, go_p, sk1, sk0, jmp_p, jmp, go};
      exp = {mlvl[3], mlvl[2], mrise[0], mlvl[3], mlvl[2],
             mrise[1], mlvl[1], mrise[0]};
      check("model", 32'(act), 32'(exp));
   endtask

   initial begin
      int first, np, jp, jl, bad;
      int hold [4];
      bit [3:0] rv;

      // {raw sk1,sk0,jmp,go}, cycles, final {sk1,sk0,jmp_p,jmp,go}, counts
      tbl[0] = '{4'b0000, 10, 5'b00000, 0, 0, 0};
      tbl[1] = '{4'b0001, 20, 5'b00000, 1, 0, 0};
      tbl[2] = '{4'b0000, 12, 5'b00000, 0, 0, 0};
      tbl[3] = '{4'b0001, 12, 5'b00000, 1, 0, 0};
      tbl[4] = '{4'b0000, 10, 5'b00000, 0, 0, 0};
      tbl[5] = '{4'b0100, 10, 5'b01000, 0, 0, 0};
      tbl[6] = '{4'b1000, 10, 5'b10000, 0, 0, 0};
      tbl[7] = '{4'b1100, 10, 5'b11000, 0, 0, 0};
      tbl[8] = '{4'b0010, 15, 5'b00010, 0, 1, 10};
      tbl[9] = '{4'b0000, 15, 5'b00000, 0, 0, 5};

      // reset with all raw inputs high, then first pulse at edge 5
      drive(1'b1, 4'hF);
      tick();
      tick();
      check("reset_out", 32'({go, jmp, jmp_p, sk0, sk1}), 32'd0);
      drive(1'b0, 4'hF);
      first = -1;
      np = 0;
      jp = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (go) begin
            np++;
            if (first < 0) first = i;
         end
         if (jmp_p) jp++;
      end
      check("go_first_edge", 32'(first), 32'd5);
      check("go_pulses", 32'(np), 32'd1);
      check("jmp_p_pulses", 32'(jp), 32'd1);
      check("levels_high", 32'({jmp, sk0, sk1}), 32'h7);

      drive(1'b1, 4'h0);
      tick();
      tick();

      foreach (tbl[s]) begin
         drive(1'b0, tbl[s].raw);
         np = 0;
         jp = 0;
         jl = 0;
         for (int c = 0; c < tbl[s].cyc; c++) begin
            tick();
            if (go) np++;
            if (jmp_p) jp++;
            if (jmp) jl++;
         end
         check($sformatf("seg%0d_final", s),
               32'({sk1, sk0, jmp_p, jmp, go}), 32'(tbl[s].fin));
         check($sformatf("seg%0d_go", s), 32'(np), 32'(tbl[s].gop));
         check($sformatf("seg%0d_jmpp", s), 32'(jp), 32'(tbl[s].jpp));
         check($sformatf("seg%0d_jmplvl", s), 32'(jl), 32'(tbl[s].jlv));
      end

      // 3-cycle high glitch on go and sk0
      drive(1'b0, 4'b0101);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (go || sk0) bad++;
      end
      drive(1'b0, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (go || sk0) bad++;
      end
      check("glitch_high", 32'(bad), 32'd0);

      // 3-cycle low dip on settled sk1
      drive(1'b0, 4'b1000);
      for (int i = 0; i < 12; i++) tick();
      check("sk1_settled", 32'(sk1), 32'd1);
      drive(1'b0, 4'b0000);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (!sk1) bad++;
      end
      drive(1'b0, 4'b1000);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!sk1) bad++;
      end
      check("glitch_low", 32'(bad), 32'd0);

      // reset at edge 3 of a sk0 debounce discards the partial count
      drive(1'b0, 4'b0000);
      for (int i = 0; i < 8; i++) tick();
      drive(1'b0, 4'b0100);
      for (int i = 0; i < 3; i++) tick();
      drive(1'b1, 4'b0100);
      tick();
      check("mid_rst_sk0", 32'(sk0), 32'd0);
      drive(1'b0, 4'b0100);
      first = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sk0 && first < 0) first = i;
      end
      check("mid_rst_latency", 32'(first), 32'd5);

      // random hold lengths per channel with occasional reset
      for (int c = 0; c < 4; c++) hold[c] = 0;
      rv = 4'b0100;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < 4; c++) begin
            if (hold[c] == 0) begin
               rv[c] = 1'($urandom_range(0, 1));
               hold[c] = int'($urandom_range(1, 9));
            end
            hold[c]--;
         end
         drive(($urandom_range(0, 299) == 0), rv);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
